// File: rtl/speed_test_frame_checker.sv
// Receive-side frame checker for one speed-test port: sinks the RX stream, classifies
// frames as good/bad and accumulates frame and byte counts between start and stop.
module speed_test_frame_checker #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [255:0]          port_config,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic                  check_ready,
  output logic [127:0]          check_results
);

  typedef enum logic [1:0] {IDLE, RUNNING, STOPPING, DONE} state_t;

  state_t      state, state_next;
  logic        in_frame, skip;
  logic [15:0] frame_len;
  logic [31:0] good_frames, bad_frames;
  logic [63:0] good_bytes;

  logic        beat, frame_end, counting, skip_eff, count_frame, frame_bad;
  logic [16:0] keep_count, len_sum;
  logic [15:0] len_final;
  logic [31:0] gf_base, bf_base, gf_next, bf_next;
  logic [63:0] gb_base, gb_next;
  logic [64:0] bytes_sum;
  logic        unused_inputs;

  assign unused_inputs = ^{s_axis_tdata, port_config[255:17]};

  assign s_axis_tready = 1'b1;
  assign beat          = s_axis_tvalid;
  assign frame_end     = beat & s_axis_tlast;

  always_comb begin
    keep_count = '0;
    for (int i = 0; i < KEEP_WIDTH; i++)
      keep_count = keep_count + 17'(s_axis_tkeep[i]);
  end

  assign len_sum   = {1'b0, frame_len} + (beat ? keep_count : 17'd0);
  assign len_final = len_sum[16] ? 16'hFFFF : len_sum[15:0];
  assign frame_bad = s_axis_tuser | (port_config[16] & (len_final != port_config[15:0]));

  // A start landing inside a frame must also drop that frame if its tlast is this very beat.
  assign skip_eff    = skip | (start & in_frame);
  assign counting    = start | (state == RUNNING) | (state == STOPPING);
  assign count_frame = frame_end & counting & ~skip_eff;

  always_comb begin
    gf_base   = start ? 32'd0 : good_frames;
    bf_base   = start ? 32'd0 : bad_frames;
    gb_base   = start ? 64'd0 : good_bytes;
    gf_next   = gf_base;
    bf_next   = bf_base;
    gb_next   = gb_base;
    bytes_sum = {1'b0, gb_base} + {49'd0, len_final};
    if (count_frame) begin
      if (frame_bad) begin
        bf_next = (bf_base == 32'hFFFF_FFFF) ? bf_base : bf_base + 32'd1;
      end else begin
        gf_next = (gf_base == 32'hFFFF_FFFF) ? gf_base : gf_base + 32'd1;
        gb_next = bytes_sum[64] ? 64'hFFFF_FFFF_FFFF_FFFF : bytes_sum[63:0];
      end
    end
  end

  // A stop on a frame's own tlast beat has nothing left to drain, so it goes straight to DONE.
  always_comb begin
    state_next = state;
    if (start) begin
      state_next = RUNNING;
    end else begin
      case (state)
        RUNNING:  if (stop) state_next = (in_frame && !frame_end) ? STOPPING : DONE;
        STOPPING: if (frame_end) state_next = DONE;
        default:  state_next = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      check_ready <= 1'b1;
      in_frame    <= 1'b0;
      skip        <= 1'b0;
      frame_len   <= '0;
      good_frames <= '0;
      bad_frames  <= '0;
      good_bytes  <= '0;
    end else begin
      state       <= state_next;
      check_ready <= (state_next == IDLE) || (state_next == DONE);
      good_frames <= gf_next;
      bad_frames  <= bf_next;
      good_bytes  <= gb_next;
      if (frame_end) begin
        in_frame  <= 1'b0;
        skip      <= 1'b0;
        frame_len <= '0;
      end else begin
        if (beat) begin
          in_frame  <= 1'b1;
          frame_len <= len_final;
        end
        if (start && in_frame)
          skip <= 1'b1;
      end
    end
  end

  assign check_results = {good_bytes, bad_frames, good_frames};

endmodule

// File: tb/tb_speed_test_frame_checker.sv
// Directed bench for speed_test_frame_checker: a scoreboard queue holds the expected result
// word for every test, popped by a monitor each time check_ready rises.
module tb_speed_test_frame_checker;

  localparam int DATA_WIDTH = 64;
  localparam int KEEP_WIDTH = DATA_WIDTH / 8;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  start = 1'b0;
  logic                  stop = 1'b0;
  logic [255:0]          port_config = '0;
  logic [DATA_WIDTH-1:0] s_axis_tdata = '0;
  logic [KEEP_WIDTH-1:0] s_axis_tkeep = '0;
  logic                  s_axis_tlast = 1'b0;
  logic                  s_axis_tuser = 1'b0;
  logic                  s_axis_tvalid = 1'b0;
  logic                  s_axis_tready;
  logic                  check_ready;
  logic [127:0]          check_results;

  int assert_count = 0;
  int fail_count   = 0;
  logic [127:0] exp_queue[$];
  logic prev_ready = 1'b1;

  speed_test_frame_checker #(.DATA_WIDTH(DATA_WIDTH), .KEEP_WIDTH(KEEP_WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .port_config(port_config),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .s_axis_tuser(s_axis_tuser), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .check_ready(check_ready), .check_results(check_results)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] res(input logic [63:0] bytes, input logic [31:0] bad,
                                       input logic [31:0] good);
    return {bytes, bad, good};
  endfunction

  task automatic compare(input string name, input logic [127:0] act, input logic [127:0] exp);
    assert_count++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every rising check_ready outside reset presents a final result to be scored.
  always @(negedge clk) begin
    if (rst) begin
      prev_ready = 1'b1;
    end else begin
      if (check_ready && !prev_ready) begin
        if (exp_queue.size() == 0) begin
          assert_count++;
          fail_count++;
          $display("[TB] FAIL scoreboard: unexpected result %h", check_results);
        end else begin
          compare("scoreboard", check_results, exp_queue.pop_front());
        end
      end
      prev_ready = check_ready;
    end
  end

  task automatic apply_stimulus(input logic valid, input logic [KEEP_WIDTH-1:0] keep,
                                input logic last, input logic user,
                                input logic do_start, input logic do_stop);
    s_axis_tvalid = valid;
    s_axis_tkeep  = keep;
    s_axis_tlast  = last;
    s_axis_tuser  = user;
    s_axis_tdata  = DATA_WIDTH'($urandom);
    start         = do_start;
    stop          = do_stop;
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    start         = 1'b0;
    stop          = 1'b0;
  endtask

  task automatic check_output(input string name, input logic [127:0] exp_results,
                              input logic exp_ready);
    @(negedge clk);
    compare({name, ".results"}, check_results, exp_results);
    compare({name, ".ready"}, {127'd0, check_ready}, {127'd0, exp_ready});
    @(posedge clk);
    #1;
  endtask

  // Full-width beats except the last one; tlast only when with_last is set.
  task automatic send_beats(input int first, input int count, input logic with_last,
                            input logic [KEEP_WIDTH-1:0] last_keep, input logic user,
                            input int start_at, input int stop_at);
    for (int b = first; b < first + count; b++) begin
      if (with_last && b == first + count - 1)
        apply_stimulus(1'b1, last_keep, 1'b1, user, b == start_at, b == stop_at);
      else
        apply_stimulus(1'b1, '1, 1'b0, 1'b0, b == start_at, b == stop_at);
    end
  endtask

  task automatic send_frame(input logic [KEEP_WIDTH-1:0] last_keep, input logic user);
    send_beats(0, 8, 1'b1, last_keep, user, -1, -1);
  endtask

  logic users[10]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic shorts[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  task automatic mixed_run(input logic check_en, input logic [127:0] expected);
    port_config = {239'd0, check_en, 16'd64};
    apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int f = 0; f < 10; f++)
      send_frame(shorts[f] ? 8'h0F : 8'hFF, users[f]);
    exp_queue.push_back(expected);
    apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_output("mixed_done", expected, 1'b1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    compare("reset.results", check_results, 128'd0);
    compare("reset.ready", {127'd0, check_ready}, 128'd1);
    compare("reset.tready", {127'd0, s_axis_tready}, 128'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    port_config = {239'd0, 1'b1, 16'd64};
    send_frame(8'hFF, 1'b0);
    check_output("idle_frame", 128'd0, 1'b1);

    $display("[TB] basic count");
    apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_output("basic_start", 128'd0, 1'b0);
    for (int f = 0; f < 10; f++) send_frame(8'hFF, 1'b0);
    exp_queue.push_back(res(64'd640, 32'd0, 32'd10));
    apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_output("basic_done", res(64'd640, 32'd0, 32'd10), 1'b1);

    $display("[TB] bad frames, length check on then off");
    mixed_run(1'b1, res(64'd320, 32'd5, 32'd5));
    mixed_run(1'b0, res(64'd440, 32'd3, 32'd7));

    $display("[TB] stop mid-frame");
    port_config = {239'd0, 1'b1, 16'd64};
    apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_output("restart_clear", 128'd0, 1'b0);
    send_frame(8'hFF, 1'b0);
    send_frame(8'hFF, 1'b0);
    send_beats(0, 3, 1'b0, 8'hFF, 1'b0, -1, 2);
    check_output("stopping_wait", res(64'd128, 32'd0, 32'd2), 1'b0);
    send_beats(3, 4, 1'b0, 8'hFF, 1'b0, -1, -1);
    check_output("stopping_hold", res(64'd128, 32'd0, 32'd2), 1'b0);
    exp_queue.push_back(res(64'd192, 32'd0, 32'd3));
    send_beats(7, 1, 1'b1, 8'hFF, 1'b0, -1, -1);
    check_output("stopping_done", res(64'd192, 32'd0, 32'd3), 1'b1);

    $display("[TB] start mid-frame");
    send_beats(0, 3, 1'b0, 8'hFF, 1'b0, -1, -1);
    send_beats(3, 1, 1'b0, 8'hFF, 1'b0, 3, -1);
    check_output("skip_start", 128'd0, 1'b0);
    send_beats(4, 4, 1'b1, 8'hFF, 1'b0, -1, -1);
    check_output("skip_tail", 128'd0, 1'b0);
    send_frame(8'hFF, 1'b0);
    send_frame(8'hFF, 1'b0);
    exp_queue.push_back(res(64'd128, 32'd0, 32'd2));
    apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("[TB] start coincident with first beat");
    port_config = {239'd0, 1'b0, 16'd64};
    send_beats(0, 1, 1'b1, 8'hFF, 1'b0, 0, -1);
    exp_queue.push_back(res(64'd8, 32'd0, 32'd1));
    apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    send_beats(0, 8, 1'b1, 8'hFF, 1'b0, 0, -1);
    exp_queue.push_back(res(64'd64, 32'd0, 32'd1));
    apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0);
    check_output("done_frame", res(64'd64, 32'd0, 32'd1), 1'b1);
    apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_output("done_stop", res(64'd64, 32'd0, 32'd1), 1'b1);

    $display("[TB] start and stop together");
    apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_output("start_stop", 128'd0, 1'b0);
    exp_queue.push_back(128'd0);
    apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("[TB] reset mid-test");
    port_config = {239'd0, 1'b1, 16'd64};
    apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b0);
    send_beats(0, 3, 1'b0, 8'hFF, 1'b0, -1, -1);
    rst = 1'b1;
    #1;
    compare("async_reset.results", check_results, 128'd0);
    compare("async_reset.ready", {127'd0, check_ready}, 128'd1);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_beats(3, 1, 1'b0, 8'hFF, 1'b0, -1, -1);
    send_beats(4, 1, 1'b0, 8'hFF, 1'b0, 4, -1);
    send_beats(5, 3, 1'b1, 8'hFF, 1'b0, -1, -1);
    check_output("reset_tail", 128'd0, 1'b0);
    send_frame(8'hFF, 1'b0);
    exp_queue.push_back(res(64'd64, 32'd0, 32'd1));
    apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_output("reset_done", res(64'd64, 32'd0, 32'd1), 1'b1);

    repeat (4) @(posedge clk);
    compare("scoreboard_drained", 128'(exp_queue.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
